// File: rtl/cordic_phase_gen.sv
// Phase-accumulator NCO feeding the 8-bit CORDIC core: folds each phase into [-pi/2, pi/2],
// scales it to a Q2.6 radian angle, and delays the cosine-negate flag to match the core latency.
module cordic_phase_gen #(
   parameter int CORDIC_LAT = 14
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              fcw_load,
   input  logic [15:0]       fcw_in,
   output logic signed [7:0] angle,
   output logic              angle_valid,
   output logic              res_valid,
   output logic              res_cos_neg
);

   logic        [15:0]           r_phase_p0;
   logic        [15:0]           r_fcw;
   logic signed [7:0]            r_angle_p1;
   logic                         r_vld_p1;
   logic                         r_neg_p1;
   logic        [CORDIC_LAT-1:0] r_dly_vld;
   logic        [CORDIC_LAT-1:0] r_dly_neg;
   logic signed [16:0]           w_s;
   logic signed [16:0]           w_fold;
   logic                         w_neg;

   // Radians = s' * 2*pi / 2^16, expressed in Q2.6 with round-half-up.
   function automatic logic signed [7:0] scale_rnd(input logic signed [16:0] s);
      logic signed [31:0] prod;
      prod = s * 32'sd25736;
      prod = prod + 32'sd2097152;
      return 8'(prod >>> 22);
   endfunction

   // Mirror phases beyond +/-quarter turn back into range; the mirrored half needs cos negated.
   always_comb begin
      w_s    = signed'({r_phase_p0[15], r_phase_p0});
      w_fold = w_s;
      w_neg  = 1'b0;
      if (w_s > 17'sd16384) begin
         w_fold = 17'sd32768 - w_s;
         w_neg  = 1'b1;
      end else if (w_s < -17'sd16384) begin
         w_fold = -17'sd32768 - w_s;
         w_neg  = 1'b1;
      end
   end

   // p0: phase accumulator and frequency word
   always_ff @(posedge clk) begin
      if (rst) begin
         r_phase_p0 <= '0;
         r_fcw      <= '0;
      end else begin
         if (en)
            r_phase_p0 <= r_phase_p0 + r_fcw;
         if (fcw_load)
            r_fcw <= fcw_in;
      end
   end

   // p1: folded and scaled angle, registered from the pre-increment phase
   always_ff @(posedge clk) begin
      if (rst) begin
         r_angle_p1 <= '0;
         r_neg_p1   <= 1'b0;
         r_vld_p1   <= 1'b0;
      end else begin
         r_vld_p1 <= en;
         if (en) begin
            r_angle_p1 <= scale_rnd(w_fold);
            r_neg_p1   <= w_neg;
         end
      end
   end

   // Flag delay line: shifts every cycle so en bubbles travel intact to the core output.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_dly_vld <= '0;
         r_dly_neg <= '0;
      end else begin
         r_dly_vld[0] <= r_vld_p1;
         r_dly_neg[0] <= r_neg_p1;
         for (int k = 1; k < CORDIC_LAT; k++) begin
            r_dly_vld[k] <= r_dly_vld[k-1];
            r_dly_neg[k] <= r_dly_neg[k-1];
         end
      end
   end

   assign angle       = r_angle_p1;
   assign angle_valid = r_vld_p1;
   assign res_valid   = r_dly_vld[CORDIC_LAT-1];
   assign res_cos_neg = r_dly_neg[CORDIC_LAT-1];

endmodule

// File: tb/tb_cordic_phase_gen.sv
// Scoreboard bench for cordic_phase_gen: angles and delayed flags are queued as stimulus is
// driven and compared when the outputs are due.
module tb_cordic_phase_gen;

   localparam int L = 14;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              en = 1'b0;
   logic              fcw_load = 1'b0;
   logic [15:0]       fcw_in = '0;
   logic signed [7:0] angle;
   logic              angle_valid;
   logic              res_valid;
   logic              res_cos_neg;

   cordic_phase_gen #(.CORDIC_LAT(L)) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .fcw_load    (fcw_load),
      .fcw_in      (fcw_in),
      .angle       (angle),
      .angle_valid (angle_valid),
      .res_valid   (res_valid),
      .res_cos_neg (res_cos_neg)
   );

   always #5 clk = ~clk;

   typedef struct {int ang; bit neg;} ang_t;
   typedef struct {int due; bit neg;} res_t;

   ang_t q_ang[$];
   res_t q_res[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   phase_m = 0;
   int   fcw_m = 0;
   int   held = 0;
   bit   exp_av = 1'b0;

   task automatic chk(input string tag, input int obs, input int exp_v);
      checks++;
      if (obs !== exp_v) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
      end
   endtask

   // Reference angle from the unsigned phase: the folded band is 16385..49151.
   function automatic int f_model(input int p, output bit neg);
      int sp;
      if (p > 16384 && p < 49152) begin
         sp  = 32768 - p;
         neg = 1'b1;
      end else begin
         sp  = (p >= 49152) ? p - 65536 : p;
         neg = 1'b0;
      end
      return $rtoi($floor((real'(sp) * 25736.0 + 2097152.0) / 4194304.0));
   endfunction

   task automatic cycle(input bit r, input bit e, input bit l, input int f);
      bit   n;
      int   a;
      bit   exp_rv;
      ang_t ea;
      res_t er;
      rst = r; en = e; fcw_load = l; fcw_in = 16'(f);
      @(posedge clk);
      cyc++;
      if (r) begin
         phase_m = 0; fcw_m = 0; held = 0; exp_av = 1'b0;
         q_ang.delete(); q_res.delete();
      end else begin
         exp_av = e;
         if (e) begin
            a = f_model(phase_m, n);
            q_ang.push_back('{a, n});
            q_res.push_back('{cyc + L, n});
            phase_m = (phase_m + fcw_m) % 65536;
         end
         if (l) fcw_m = f;
      end
      @(negedge clk);
      chk("angle_valid", int'(angle_valid), int'(exp_av));
      if (exp_av && q_ang.size() > 0) begin
         ea = q_ang.pop_front();
         held = ea.ang;
      end
      chk("angle", int'(angle), held);
      exp_rv = (q_res.size() > 0) && (q_res[0].due == cyc);
      chk("res_valid", int'(res_valid), int'(exp_rv));
      if (exp_rv) begin
         er = q_res.pop_front();
         chk("res_cos_neg", int'(res_cos_neg), int'(er.neg));
      end
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 0);
   endtask

   int t2_ang[17]  = '{0, 25, 50, 75, 101, 75, 50, 25, 0, -25, -50, -75, -101, -75, -50, -25, 0};
   bit t2_neg[17]  = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
   int t4_ang[4]   = '{0, 0, 50, 50};
   bit t4_en[4]    = '{1, 0, 1, 0};
   int t5_ang[5]   = '{0, 25, 50, 50, -50};

   initial begin
      int k;
      @(negedge clk);

      // Reset with en and fcw_load asserted: nothing loaded, all outputs cleared
      cycle(1'b1, 1'b1, 1'b1, 1234);
      cycle(1'b1, 1'b1, 1'b1, 1234);
      chk("rst_angle", int'(angle), 0);
      chk("rst_angle_valid", int'(angle_valid), 0);
      chk("rst_res_valid", int'(res_valid), 0);
      chk("rst_res_cos_neg", int'(res_cos_neg), 0);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 1'b1, 1'b0, 0);
         chk("rst_noload_angle", int'(angle), 0);
      end
      drain(L + 2);

      // fcw=4096 full turn, then flags L cycles later
      cycle(1'b0, 1'b0, 1'b1, 4096);
      k = 0;
      for (int i = 0; i < 17 + L + 2; i++) begin
         cycle(1'b0, i < 17, 1'b0, 0);
         if (i < 17) chk("t2_angle_tab", int'(angle), t2_ang[i]);
         if (res_valid && k < 17) begin
            chk("t3_neg_tab", int'(res_cos_neg), int'(t2_neg[k]));
            chk("t3_res_delay", i, k + L);
            k++;
         end
      end
      chk("t3_res_count", k, 17);

      // en toggling with fcw=8192
      cycle(1'b1, 1'b0, 1'b0, 0);
      cycle(1'b0, 1'b0, 1'b1, 8192);
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, t4_en[i], 1'b0, 0);
         chk("t4_angle", int'(angle), t4_ang[i]);
         chk("t4_valid", int'(angle_valid), int'(t4_en[i]));
      end
      drain(L + 2);

      // FCW reload coinciding with en: that step still uses the old word
      cycle(1'b1, 1'b0, 1'b0, 0);
      cycle(1'b0, 1'b0, 1'b1, 4096);
      for (int i = 0; i < 5; i++) begin
         cycle(1'b0, 1'b1, i == 1, (i == 1) ? 16384 : 0);
         chk("t5_angle", int'(angle), t5_ang[i]);
      end

      // Reset mid-run with flags in flight
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 0);
      cycle(1'b1, 1'b0, 1'b0, 0);
      chk("t6_angle", int'(angle), 0);
      chk("t6_angle_valid", int'(angle_valid), 0);
      chk("t6_res_valid", int'(res_valid), 0);
      chk("t6_res_cos_neg", int'(res_cos_neg), 0);
      cycle(1'b0, 1'b0, 1'b1, 4096);
      k = 0;
      for (int i = 0; i < L + 4; i++) begin
         cycle(1'b0, 1'b1, 1'b0, 0);
         if (i == 0) chk("t6_first_angle", int'(angle), 0);
         if (res_valid && k == 0) begin
            chk("t6_first_res_at", i, L);
            k++;
         end
      end
      chk("t6_res_seen", k, 1);
      drain(L + 2);
      chk("sb_empty", q_res.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cordic_phase_gen.md
Name: cordic_phase_gen

Overview:
- Upstream stage of the 8-bit CORDIC sine/cosine core: a numerically controlled oscillator (NCO) that produces the core's angle input.
- A 16-bit phase accumulator advances by a programmable frequency control word (FCW).
- Each phase is folded into the core's convergence range [-pi/2, pi/2] and converted to a signed Q2.6 radian angle.
- The resulting cosine-negate flag is delayed to line up with the core's sine/cosine outputs, so the downstream sign fix needs no further timing logic.

Parameters:
- CORDIC_LAT, 14, latency of the CORDIC core in clk cycles from angle to sine/cosine; depth of the flag delay line (1..32).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; synchronous, active-high.
- en  input  1  advance enable; one phase step and one angle output per cycle it is high.
- fcw_load  input  1  load fcw_in into the FCW register.
- fcw_in  input  16  frequency control word, unsigned, units of 2^-16 turn per step.
- angle  output  8  signed Q2.6 radians, drives the core's angle input.
- angle_valid  output  1  angle updated this cycle.
- res_valid  output  1  angle_valid delayed by CORDIC_LAT cycles.
- res_cos_neg  output  1  cosine-negate flag delayed by CORDIC_LAT cycles; high means negate the core's cosine.

Behaviour:
- Reset (rst high at a posedge) clears:
  - phase_q (16 b) and fcw_q (16 b) to 0.
  - angle, angle_valid, res_valid and res_cos_neg to 0.
  - The whole delay line.
- Reset has priority over en and fcw_load. Reset mid-run discards in-flight flags; no res_valid appears for pre-reset angles.
- FCW load:
  - On fcw_load, fcw_q <= fcw_in.
  - If en is high in the same cycle, that cycle's increment uses the old fcw_q.
- Advance, on each posedge with en=1:
  - phase_q <= phase_q + fcw_q, modulo 2^16 (wrap silently).
  - angle <= F(phase_q), i.e. the pre-increment phase.
  - angle_valid <= 1.
  - The first angle after reset is F(0) = 0.
- Hold, on a posedge with en=0:
  - phase_q and angle hold.
  - angle_valid <= 0.
- Fold, combinational, computed in 17-bit signed arithmetic:
  - Let s = phase_q as signed 16-bit, range [-32768, 32767].
  - If s > 16384: s' = 32768 - s, neg = 1.
  - Else if s < -16384: s' = -32768 - s, neg = 1.
  - Else: s' = s, neg = 0.
  - Boundary cases: s = +/-16384 is not folded; s = -32768 gives s' = 0, neg = 1.
- Scale:
  - F = (s' * 25736 + 2^21) >>> 22, arithmetic shift, where 25736 = round(2*pi*2^12).
  - Output range is [-101, 101], so no saturation is needed.
- Delay line:
  - {angle_valid, neg registered alongside angle} shifts through CORDIC_LAT registers every cycle, independent of en.
  - The tail drives res_valid and res_cos_neg.
  - res_valid rises exactly CORDIC_LAT cycles after the matching angle_valid.
  - Bubbles from en=0 propagate unchanged.
- No combinational path from any input to any output.

Test Plan:
1. Assert rst for 2 cycles with en=1 and fcw_load=1 -> angle=0, angle_valid=0, res_valid=0, res_cos_neg=0, phase_q=0; nothing is loaded.
2. Load fcw=4096, then hold en=1 for 17 cycles -> the 16 angles in the first 16 en cycles are:
   - 0, 25, 50, 75, 101 with neg 0.
   - 75, 50, 25, 0, -25, -50, -75 with neg 1.
   - -101, -75, -50, -25 with neg 0.
   - The 17th angle is 0 again, confirming the 2^16 wrap.
3. Same stimulus, CORDIC_LAT=14 -> res_valid rises 14 cycles after angle_valid; res_cos_neg reproduces the neg pattern above shifted by 14.
4. fcw=8192 with en toggling 1,0,1,0 -> angle 0, hold 0, 50, hold 50; angle_valid 1,0,1,0; res_valid shows the same bubbles 14 cycles later.
5. fcw=4096 running; assert fcw_load with fcw_in=16384 in the same cycle as en -> that step adds 4096, later steps add 16384.
6. Assert rst mid-run with flags in flight -> all outputs 0 on the next cycle; no res_valid for 14 cycles after the first post-reset angle_valid, whose angle is 0.
